fixed_mult_arbiter: RTL and testbench
=====================================

# fixed_mult_arbiter

- Shares one fixed-point multiplier datapath among `n_requesters` audio-effect stages, such as the gain, distortion and filter stages.
- Arbitration is round-robin with a per-requester valid/ready handshake.
- Operands and the product are registered around the combinational `fixed_multiply` instance.
- The product returns on a shared result bus, tagged with a one-hot response strobe.

## Interface
- `fractional_size`, 12: fractional bits of the Q format.
- `operand_size`, 32: operand and result width, two's complement.
- `n_requesters`, 4: number of requesters, range 2..16.
- `clk` in 1: the single clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in `n_requesters`: requester i has an operation pending.
- `req_a` in `n_requesters`×`operand_size`: operand a per requester.
- `req_b` in `n_requesters`×`operand_size`: operand b per requester.
- `req_ready` out `n_requesters`: one-hot or zero; an operation is accepted when `req_valid[i] & req_ready[i]` at a rising edge.
- `resp_valid` out `n_requesters`: one-hot one-cycle strobe; `resp_c` belongs to requester i.
- `resp_c` out `operand_size`: product, held until the next response.
- `busy` out 1: high when state is not IDLE.

## Operation
- **States:**
  - IDLE: nothing in flight.
  - CALC: operands registered, multiply settling, product captured at the end of the cycle.
  - RESP: response presented.
- **Grant rule:**
  - Grants may be issued only in IDLE or RESP, and only when `rst`=0.
  - Scan the indices `ptr`, `ptr+1`, … mod `n_requesters`. The first i with `req_valid[i]`=1 gets `req_ready[i]`=1, combinationally in the same cycle. All other ready bits are 0.
  - `req_ready[i]` is never high while `req_valid[i]`=0.
- **On handshake:**
  - Latch `req_a[i]`, `req_b[i]` and id=i into operand registers.
  - Set `ptr` ← (i+1) mod `n_requesters`.
  - Next state is CALC.
- **Transitions:**
  - IDLE→CALC on a grant; otherwise stay in IDLE.
  - CALC→RESP always; the product register loads at this edge.
  - RESP→CALC on a grant.
  - RESP→IDLE when there is no grant.
- **In RESP:** `resp_valid[id]`=1 and `resp_c` = product register. Back-to-back operations overlap RESP with the next grant.
- **Requester rules:**
  - The requester holds `req_valid`, `req_a` and `req_b` stable until ready.
  - Dropping `req_valid` before ready is legal and leaves no trace. `ptr` changes only on a grant.
- **Arithmetic:**
  - Sign-extend a and b to `operand_size`+`fractional_size` bits.
  - Take the product mod 2^(`operand_size`+`fractional_size`).
  - `resp_c` = product bits [`operand_size`+`fractional_size`−1 : `fractional_size`].
  - This is a floor (toward −∞) rescale. Overflow wraps; there is no saturation.
- **Reset:**
  - At an edge with `rst`=1: state←IDLE, `ptr`←0, operand, id and product registers←0.
  - An in-flight operation is discarded and produces no response.
  - `req_ready` is forced to 0 while `rst`=1.

## Timing
- **Reset values:** `req_ready`=0, `resp_valid`=0, `resp_c`=0, `busy`=0.
- **Latency:** a handshake in cycle t gives `resp_valid` in cycle t+2 (state CALC in t+1, RESP in t+2).
- **Throughput:** one operation every 2 cycles under continuous demand, with grants in t, t+2, t+4, ….
- **Single requester:** a lone requester that reasserts valid right after acceptance is regranted in its own RESP cycle.
- **`resp_c` hold:** `resp_c` stays valid after the strobe and changes only when the next product loads.
- **Critical path:** the multiplier path is register-to-register, operand regs to product reg, in one cycle.
- **`busy`:** high in CALC and RESP.

## Test plan
All cases use Q20.12 (`fractional_size`=12, `operand_size`=32).

1. **Basic product.** After reset, requester 0 sends a=0x00001800 (1.5), b=0x00002000 (2.0).
   - `req_ready[0]` is high the same cycle.
   - `resp_valid`=0001 two cycles later with `resp_c`=0x00003000.
   - `busy` is 1 for 2 cycles, then 0.
2. **Signs and floor rounding.**
   - a=0xFFFFE800 (−1.5), b=0x00002000 → 0xFFFFD000.
   - a=0x00000001, b=0x00000001 → 0x00000000.
   - a=0xFFFFFFFF, b=0x00000001 → 0xFFFFFFFF.
3. **Overflow wraps.** a=0x7FFFF000, b=0x00002000 → 0xFFFFE000, with no saturation.
4. **Round-robin fairness.** Requesters 0..3 all assert valid continuously from reset.
   - Grants go 0,1,2,3,0 at a 2-cycle spacing.
   - Each `resp_valid` strobe matches its own requester's operands.
   - `req_ready` is never multi-hot.
5. **Pointer skip and withdraw.** After a grant to requester 2, only requesters 1 and 3 are valid.
   - Requester 3 is granted next.
   - Requester 1 drops valid before being granted; no grant or response goes to 1, and `ptr` is unchanged.
6. **Reset mid-operation.** Assert `rst` in the CALC cycle.
   - No `resp_valid` appears.
   - Next cycle: all outputs are 0, and with all requesters valid the next grant goes to requester 0.

Source files
------------

// File: rtl/fixed_mult_arbiter_if.sv
// Request/response bundle between the audio-effect stages and the shared
// fixed-point multiplier. Operands are packed per requester.
interface fixed_mult_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int OP_W  = 32
);
  logic [N_REQ-1:0]           req_valid;
  logic [N_REQ-1:0][OP_W-1:0] req_a;
  logic [N_REQ-1:0][OP_W-1:0] req_b;
  logic [N_REQ-1:0]           req_ready;
  logic [N_REQ-1:0]           resp_valid;
  logic [OP_W-1:0]            resp_c;
  logic                       busy;

  // Effect stages drive requests and consume responses.
  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, resp_valid, resp_c, busy
  );

  // The arbiter consumes requests and produces responses.
  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, resp_valid, resp_c, busy
  );
endinterface

// File: rtl/fixed_mult_arbiter.sv
// Round-robin arbiter sharing one Q-format multiplier among several
// requesters. Operands are registered on grant, the product is registered
// one cycle later, and the result is strobed back to the owning requester.

// Combinational Q-format multiply: sign-extend to operand_size+fractional_size
// bits, keep the product modulo that width, drop the fractional bits (floor).
module fixed_multiply #(
  parameter int fractional_size = 12,
  parameter int operand_size    = 32
) (
  input  logic [operand_size-1:0] i_a,
  input  logic [operand_size-1:0] i_b,
  output logic [operand_size-1:0] o_c
);
  localparam int P_W = operand_size + fractional_size;

  logic signed [P_W-1:0] w_a_ext;
  logic signed [P_W-1:0] w_b_ext;
  logic signed [P_W-1:0] w_full;

  assign w_a_ext = {{fractional_size{i_a[operand_size-1]}}, i_a};
  assign w_b_ext = {{fractional_size{i_b[operand_size-1]}}, i_b};
  assign w_full  = w_a_ext * w_b_ext;
  // Logical shift then truncation selects bits [P_W-1:fractional_size].
  assign o_c     = operand_size'(w_full >> fractional_size);
endmodule

module fixed_mult_arbiter #(
  parameter int fractional_size = 12,
  parameter int operand_size    = 32,
  parameter int n_requesters    = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  fixed_mult_arbiter_if.slave  bus
);
  localparam int ID_W = $clog2(n_requesters);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ID_W-1:0]         r_ptr;
  logic [ID_W-1:0]         r_id;
  logic [operand_size-1:0] r_a;
  logic [operand_size-1:0] r_b;
  logic [operand_size-1:0] r_prod;
  logic [operand_size-1:0] w_prod;
  logic                    w_can_grant;
  logic                    w_grant;
  logic [ID_W-1:0]         w_grant_id;
  logic [ID_W-1:0]         w_scan_id;
  logic [n_requesters-1:0] w_ready;
  logic [n_requesters-1:0] w_resp_valid;

  fixed_multiply #(
    .fractional_size (fractional_size),
    .operand_size    (operand_size)
  ) u_mul (
    .i_a (r_a),
    .i_b (r_b),
    .o_c (w_prod)
  );

  // Round-robin scan from r_ptr; first valid requester wins, only while the
  // datapath can accept (IDLE or RESP) and reset is low.
  always_comb begin
    w_grant     = 1'b0;
    w_grant_id  = '0;
    w_scan_id   = '0;
    w_can_grant = !i_rst && ((r_state == S_IDLE) || (r_state == S_RESP));
    if (w_can_grant) begin
      for (int k = 0; k < n_requesters; k++) begin
        w_scan_id = ID_W'((int'(r_ptr) + k) % n_requesters);
        if (!w_grant && bus.req_valid[w_scan_id]) begin
          w_grant    = 1'b1;
          w_grant_id = w_scan_id;
        end else begin
          w_grant    = w_grant;
        end
      end
    end else begin
      w_grant = 1'b0;
    end
    if (w_grant) begin
      w_ready = n_requesters'(1) << w_grant_id;
    end else begin
      w_ready = '0;
    end
  end

  // State register with synchronous reset; an in-flight op is simply dropped.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: a grant always moves to CALC, CALC always to RESP.
  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE:  w_state_nxt = w_grant ? S_CALC : S_IDLE;
      S_CALC:  w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = w_grant ? S_CALC : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture and pointer advance on handshake; product loads as CALC ends.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr  <= '0;
      r_id   <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_prod <= '0;
    end else begin
      if (w_grant) begin
        r_a   <= bus.req_a[w_grant_id];
        r_b   <= bus.req_b[w_grant_id];
        r_id  <= w_grant_id;
        r_ptr <= ID_W'((int'(w_grant_id) + 1) % n_requesters);
      end else begin
        r_ptr <= r_ptr;
      end
      if (r_state == S_CALC) begin
        r_prod <= w_prod;
      end else begin
        r_prod <= r_prod;
      end
    end
  end

  // Response strobe decodes the owner id while presenting the product.
  always_comb begin
    w_resp_valid = '0;
    if (r_state == S_RESP) begin
      w_resp_valid[r_id] = 1'b1;
    end else begin
      w_resp_valid = '0;
    end
  end

  assign bus.req_ready  = w_ready;
  assign bus.resp_valid = w_resp_valid;
  assign bus.resp_c     = r_prod;
  assign bus.busy       = (r_state != S_IDLE);
endmodule

// File: tb/tb_fixed_mult_arbiter.sv
// Bench for fixed_mult_arbiter: directed vector table, round-robin and
// withdraw sequences, randomized traffic against a transaction-level model,
// and reset during an operation.
module tb_fixed_mult_arbiter;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int FB = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fixed_mult_arbiter_if #(.N_REQ(N), .OP_W(W)) bus ();

  fixed_mult_arbiter #(
    .fractional_size (FB),
    .operand_size    (W),
    .n_requesters    (N)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state: pointer, grants one/two cycles ago, held product.
  int          m_ptr;
  int          m_g1;
  int          m_g2;
  logic [31:0] m_c1;
  logic [31:0] m_c2;
  logic [31:0] m_held;
  int          m_eg;
  logic [31:0] m_ea;
  logic [31:0] m_eb;
  int          last_grant;

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Floor-rescaled Q product computed with plain 64-bit signed arithmetic.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint p;
    longint q;
    p = longint'($signed(a)) * longint'($signed(b));
    q = p >>> FB;
    return q[31:0];
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_g1 = -1; m_g2 = -1;
    m_c1 = 32'd0; m_c2 = 32'd0; m_held = 32'd0;
    m_eg = -1; last_grant = -1;
  endtask

  // Outputs expected in the current cycle, given current inputs.
  task automatic model_check();
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_rv;
    m_eg = -1;
    if (!rst && m_g1 < 0) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (m_eg < 0 && bus.req_valid[idx]) m_eg = idx;
      end
    end
    exp_ready = (m_eg >= 0) ? (N'(1) << m_eg) : N'(0);
    exp_rv    = (m_g2 >= 0) ? (N'(1) << m_g2) : N'(0);
    chk("ready", 64'(bus.req_ready), 64'(exp_ready));
    chk("ready_onehot", 64'($countones(bus.req_ready) <= 1), 64'd1);
    chk("resp_valid", 64'(bus.resp_valid), 64'(exp_rv));
    chk("resp_c", 64'(bus.resp_c), 64'(m_held));
    chk("busy", 64'(bus.busy), 64'((m_g1 >= 0) || (m_g2 >= 0)));
    if (m_eg >= 0) begin
      m_ea = bus.req_a[m_eg];
      m_eb = bus.req_b[m_eg];
    end
  endtask

  // Advance the model across a rising edge.
  task automatic model_update();
    if (rst) begin
      model_reset();
    end else begin
      m_g2 = m_g1;
      m_c2 = m_c1;
      m_g1 = m_eg;
      m_c1 = (m_eg >= 0) ? ref_mul(m_ea, m_eb) : 32'd0;
      if (m_g2 >= 0) m_held = m_c2;
      if (m_eg >= 0) m_ptr = (m_eg + 1) % N;
      last_grant = m_eg;
    end
  endtask

  // One clock: check at the falling edge, update across the rising edge,
  // return 1 time unit after it so the caller can drive new inputs.
  task automatic step();
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [31:0] a, input logic [31:0] b);
    bus.req_valid[i] = v;
    bus.req_a[i]     = a;
    bus.req_b[i]     = b;
  endtask

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 3) == 0) r = 32'($signed(r) >>> 16);
    return r;
  endfunction

  initial begin
    vecs[0] = '{0, 32'h0000_1800, 32'h0000_2000, 32'h0000_3000};
    vecs[1] = '{1, 32'hFFFF_E800, 32'h0000_2000, 32'hFFFF_D000};
    vecs[2] = '{2, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000};
    vecs[3] = '{3, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF};
    vecs[4] = '{0, 32'h7FFF_F000, 32'h0000_2000, 32'hFFFF_E000};

    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    step();
    rst = 1'b0;
    #1;
    chk("reset_ready", 64'(bus.req_ready), 64'd0);
    chk("reset_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("reset_resp_c", 64'(bus.resp_c), 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    step();

    // Directed vectors: one lone requester per operation.
    for (int v = 0; v < 5; v++) begin
      set_req(vecs[v].id, 1'b1, vecs[v].a, vecs[v].b);
      #1;
      chk("vec_ready", 64'(bus.req_ready), 64'(N'(1) << vecs[v].id));
      step();
      set_req(vecs[v].id, 1'b0, 32'd0, 32'd0);
      #1;
      chk("vec_busy_calc", 64'(bus.busy), 64'd1);
      chk("vec_no_resp_calc", 64'(bus.resp_valid), 64'd0);
      step();
      chk("vec_resp_valid", 64'(bus.resp_valid), 64'(N'(1) << vecs[v].id));
      chk("vec_resp_c", 64'(bus.resp_c), 64'(vecs[v].c));
      chk("vec_busy_resp", 64'(bus.busy), 64'd1);
      step();
      chk("vec_busy_idle", 64'(bus.busy), 64'd0);
      chk("vec_resp_hold", 64'(bus.resp_c), 64'(vecs[v].c));
      chk("vec_strobe_gone", 64'(bus.resp_valid), 64'd0);
    end

    // Round-robin: everyone valid continuously from reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, rand_op(), rand_op());
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_grant", 64'(bus.req_ready), 64'(N'(1) << (k % N)));
      step();
      set_req(k % N, 1'b1, rand_op(), rand_op());
      #1;
      chk("rr_calc_no_ready", 64'(bus.req_ready), 64'd0);
      step();
    end

    // Pointer skip and withdraw: ptr is 1 here, only requester 2 valid.
    bus.req_valid = 4'b0100;
    #1;
    chk("skip_grant2", 64'(bus.req_ready), 64'h4);
    step();
    bus.req_valid = 4'b1010;
    step();
    chk("skip_grant3", 64'(bus.req_ready), 64'h8);
    step();
    bus.req_valid = 4'b0000;
    step();
    chk("withdraw_no_ready", 64'(bus.req_ready), 64'd0);
    step();
    bus.req_valid = 4'b1111;
    #1;
    chk("withdraw_ptr", 64'(bus.req_ready), 64'h1);
    step();
    bus.req_valid = 4'b0000;
    repeat (3) step();

    // Lone requester reasserting right after acceptance.
    set_req(2, 1'b1, 32'h0000_3000, 32'h0000_1000);
    step();
    step();
    chk("lone_regrant", 64'(bus.req_ready), 64'h4);
    step();
    set_req(2, 1'b0, 32'd0, 32'd0);
    repeat (3) step();

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (last_grant == i) begin
          if ($urandom_range(0, 1) == 1) set_req(i, 1'b1, rand_op(), rand_op());
          else set_req(i, 1'b0, 32'd0, 32'd0);
        end else if (bus.req_valid[i]) begin
          if ($urandom_range(0, 7) == 0) set_req(i, 1'b0, 32'd0, 32'd0);
        end else if ($urandom_range(0, 1) == 1) begin
          set_req(i, 1'b1, rand_op(), rand_op());
        end
      end
      rst = ($urandom_range(0, 49) == 0);
      step();
    end
    rst = 1'b0;
    bus.req_valid = '0;
    repeat (3) step();

    // Reset asserted during CALC discards the operation.
    set_req(2, 1'b1, 32'h0000_1800, 32'h0000_2000);
    step();
    rst = 1'b1;
    bus.req_valid = 4'b1111;
    #1;
    chk("mid_rst_busy_calc", 64'(bus.busy), 64'd1);
    chk("mid_rst_ready_forced", 64'(bus.req_ready), 64'd0);
    step();
    rst = 1'b0;
    #1;
    chk("mid_rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("mid_rst_resp_c", 64'(bus.resp_c), 64'd0);
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_grant0", 64'(bus.req_ready), 64'h1);
    repeat (4) step();
    bus.req_valid = '0;
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
